// File: rtl/mac_lane_array.sv
// Multi-lane signed multiply-accumulate engine.
// Each lane accumulates TERMS products, then applies optional bias, optional ReLU,
// an arithmetic right shift and saturation to OUT_W bits. Valid/ready on both sides.
module mac_lane_array #(
  parameter int unsigned N     = 8,
  parameter int unsigned LANES = 4,
  parameter int unsigned TERMS = 16,
  parameter int unsigned SHIFT = 0,
  parameter int unsigned OUT_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [LANES*N-1:0]     in_a_i,
  input  logic [LANES*N-1:0]     in_b_i,
  input  logic [LANES*N-1:0]     bias_i,
  input  logic                   use_bias_i,
  input  logic                   relu_en_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [LANES*OUT_W-1:0] out_data_o,
  output logic [LANES-1:0]       out_ovf_o,
  output logic                   busy_o
);

  localparam int unsigned AccW = 2 * N + $clog2(TERMS) + 1;
  localparam int unsigned CntW = (TERMS > 1) ? $clog2(TERMS) : 1;
  localparam logic signed [AccW-1:0] OutMax = AccW'((1 << (OUT_W - 1)) - 1);
  // Two's complement: ~(2^k - 1) == -2^k
  localparam logic signed [AccW-1:0] OutMin = ~OutMax;

  typedef enum logic [1:0] {StAcc, StDrain, StFin, StOut} state_e;

  state_e                   state_q;
  logic [CntW-1:0]          count_q;
  logic [LANES*N-1:0]       bias_q;
  logic                     use_bias_q;
  logic                     relu_en_q;
  logic                     out_valid_q;
  logic [LANES*OUT_W-1:0]   out_data_q;
  logic [LANES-1:0]         out_ovf_q;

  logic signed [2*N-1:0]    prod_q [LANES];
  logic                     prod_vld_q;
  logic signed [AccW-1:0]   acc_q  [LANES];

  logic [LANES*OUT_W-1:0]   sat_data;
  logic [LANES-1:0]         sat_ovf;

  logic accept;
  logic last_beat;
  logic out_fire;

  assign in_ready_o = (state_q == StAcc);
  assign accept     = in_valid_i & in_ready_o;
  assign last_beat  = accept & (count_q == CntW'(TERMS - 1));
  assign out_fire   = (state_q == StOut) & out_valid_q & out_ready_i;

  // Control FSM: beat counting, first-beat latching and registered result outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StAcc;
      count_q     <= '0;
      bias_q      <= '0;
      use_bias_q  <= 1'b0;
      relu_en_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= '0;
    end else begin
      unique case (state_q)
        StAcc: begin
          if (accept) begin
            if (count_q == '0) begin
              bias_q     <= bias_i;
              use_bias_q <= use_bias_i;
              relu_en_q  <= relu_en_i;
            end
            if (last_beat) begin
              count_q <= '0;
              state_q <= StDrain;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        StDrain: state_q <= StFin;
        StFin: begin
          out_data_q  <= sat_data;
          out_ovf_q   <= sat_ovf;
          out_valid_q <= 1'b1;
          state_q     <= StOut;
        end
        StOut: begin
          if (out_fire) begin
            out_valid_q <= 1'b0;
            state_q     <= StAcc;
          end
        end
        default: state_q <= StAcc;
      endcase
    end
  end

  // Lane datapath: registered products, accumulated one cycle later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_vld_q <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        prod_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      prod_vld_q <= accept;
      for (int i = 0; i < LANES; i++) begin
        if (accept) begin
          prod_q[i] <= $signed({{N{in_a_i[i*N+N-1]}}, in_a_i[i*N +: N]}) *
                       $signed({{N{in_b_i[i*N+N-1]}}, in_b_i[i*N +: N]});
        end
        if (out_fire) begin
          acc_q[i] <= '0;
        end else if (prod_vld_q) begin
          acc_q[i] <= acc_q[i] + $signed({{(AccW-2*N){prod_q[i][2*N-1]}}, prod_q[i]});
        end
      end
    end
  end

  // Output stage: bias, ReLU, shift and saturate each lane's accumulator.
  always_comb begin : sat_comb
    logic signed [AccW-1:0] s;
    sat_data = '0;
    sat_ovf  = '0;
    s        = '0;
    for (int i = 0; i < LANES; i++) begin
      s = acc_q[i];
      if (use_bias_q) begin
        s = s + $signed({{(AccW-N){bias_q[i*N+N-1]}}, bias_q[i*N +: N]});
      end
      if (relu_en_q && s[AccW-1]) begin
        s = '0;
      end
      s = s >>> SHIFT;
      if (s > OutMax) begin
        s          = OutMax;
        sat_ovf[i] = 1'b1;
      end else if (s < OutMin) begin
        s          = OutMin;
        sat_ovf[i] = 1'b1;
      end
      sat_data[i*OUT_W +: OUT_W] = s[OUT_W-1:0];
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_ovf_o   = out_ovf_q;
  assign busy_o      = (count_q != '0) | (state_q != StAcc);

endmodule
